cms_ctrl_sequencer: RTL and testbench

CMS_CTRL_SEQUENCER -- requirements
Module: cms_ctrl_sequencer

---
 rtl/continuous_monitoring_system_pkg.sv | 29 ++
 rtl/cms_ctrl_sequencer_if.sv | 21 ++
 rtl/cms_cmd_fifo.sv | 68 ++++++
 rtl/cms_ctrl_sequencer.sv | 137 +++++++++++++
 tb/tb_cms_ctrl_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types for the continuous monitoring system control path:
// control-port address/data shapes, register map and the sequencer command/state types.
package continuous_monitoring_system_pkg;

    localparam int unsigned CTRL_ADDR_WIDTH = 8;
    localparam int unsigned CTRL_DATA_WIDTH = 32;

    typedef logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr_t;

    localparam ctrl_addr_t TRIGGER_TRACE_START_ADDRESS         = 8'h10;
    localparam ctrl_addr_t TRIGGER_TRACE_START_ADDRESS_ENABLED = 8'h11;
    localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_LOWER_BOUND = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        SETUP,
        STROBE,
        HOLD,
        RESUME
    } cms_ctrl_seq_state_t;

    typedef struct packed {
        ctrl_addr_t                 addr;
        logic [CTRL_DATA_WIDTH-1:0] wdata;
        logic                       last;
    } cms_ctrl_cmd_t;

endpackage

// File: rtl/cms_ctrl_sequencer_if.sv
// Command push channel into the control sequencer (valid/ready handshake).
interface cms_ctrl_sequencer_if;
    import continuous_monitoring_system_pkg::*;

    logic                       s_cmd_valid;
    logic                       s_cmd_ready;
    ctrl_addr_t                 s_cmd_addr;
    logic [CTRL_DATA_WIDTH-1:0] s_cmd_wdata;
    logic                       s_cmd_last;

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_wdata, s_cmd_last,
        input  s_cmd_ready
    );

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_wdata, s_cmd_last,
        output s_cmd_ready
    );

endinterface

// File: rtl/cms_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and a single-cycle flush.
module cms_cmd_fifo
    import continuous_monitoring_system_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  cms_ctrl_cmd_t wr_data,
    input  logic          pop,
    output cms_ctrl_cmd_t rd_data,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cms_ctrl_cmd_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    // Flush wins over both ports so an abort drops a same-cycle push.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_d;
            full  <= (count_d == (AW+1)'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/cms_ctrl_sequencer.sv
// Drains queued control-register writes into the monitor, pausing cms_en around each
// batch and spacing strobes so every write is a distinct rising edge.
module cms_ctrl_sequencer
    import continuous_monitoring_system_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned PAUSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    cms_ctrl_sequencer_if.slave        cmd,
    input  logic                       sw_en,
    input  logic                       abort,
    output ctrl_addr_t                 ctrl_addr,
    output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
    output logic                       ctrl_write_enable,
    output logic                       cms_en,
    output logic                       busy,
    output logic [15:0]                writes_done
);

    localparam int unsigned TMAX = (PAUSE_CYCLES > GAP_CYCLES) ? PAUSE_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    cms_ctrl_seq_state_t        state_q, state_d;
    logic [TW-1:0]              timer_q, timer_d;
    cms_ctrl_cmd_t              cmd_in;
    cms_ctrl_cmd_t              head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    ctrl_addr_t                 addr_q;
    logic [CTRL_DATA_WIDTH-1:0] wdata_q;
    logic                       last_q;
    logic                       cms_en_q;
    logic [15:0]                writes_done_q;

    // Ready comes from the registered full flag, never from the same-cycle pop.
    assign cmd.s_cmd_ready = !fifo_full && !abort && !rst;
    assign push            = cmd.s_cmd_valid && cmd.s_cmd_ready;
    assign cmd_in          = {cmd.s_cmd_addr, cmd.s_cmd_wdata, cmd.s_cmd_last};

    cms_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (abort),
        .push    (push),
        .wr_data (cmd_in),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = PAUSE;
                    timer_d = '0;
                end
            end
            PAUSE: begin
                if (timer_q == TW'(PAUSE_CYCLES - 1)) begin
                    state_d = SETUP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SETUP: begin
                pop     = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                state_d = HOLD;
                timer_d = '0;
            end
            HOLD: begin
                if (timer_q >= TW'(GAP_CYCLES - 1)) begin
                    if (last_q) begin
                        state_d = RESUME;
                    end else if (!fifo_empty) begin
                        state_d = SETUP;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESUME: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            last_q        <= 1'b0;
            cms_en_q      <= 1'b0;
            writes_done_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (state_q == SETUP) begin
                addr_q  <= head.addr;
                wdata_q <= head.wdata;
                last_q  <= head.last;
            end
            // A strobe already on the port is counted even if abort lands with it.
            if (state_q == STROBE) begin
                writes_done_q <= writes_done_q + 1'b1;
            end
            // Every path back to IDLE (stay, RESUME, abort) loads sw_en; all others force low.
            cms_en_q <= (state_d == IDLE) ? sw_en : 1'b0;
        end
    end

    assign ctrl_addr         = addr_q;
    assign ctrl_wdata        = wdata_q;
    assign ctrl_write_enable = (state_q == STROBE) && !rst;
    assign cms_en            = cms_en_q;
    assign busy              = (state_q != IDLE) && !rst;
    assign writes_done       = writes_done_q;

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Scoreboard bench for cms_ctrl_sequencer: accepted commands queue expected writes,
// a negedge monitor pops and compares on every strobe.
module tb_cms_ctrl_sequencer;
    import continuous_monitoring_system_pkg::*;

    localparam int unsigned FIFO_DEPTH   = 8;
    localparam int unsigned PAUSE_CYCLES = 2;
    localparam int unsigned GAP_CYCLES   = 1;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       sw_en = 1'b0;
    logic                       abort = 1'b0;
    ctrl_addr_t                 ctrl_addr;
    logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata;
    logic                       ctrl_write_enable;
    logic                       cms_en;
    logic                       busy;
    logic [15:0]                writes_done;

    cms_ctrl_sequencer_if cmd_if ();

    cms_ctrl_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PAUSE_CYCLES (PAUSE_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd               (cmd_if),
        .sw_en             (sw_en),
        .abort             (abort),
        .ctrl_addr         (ctrl_addr),
        .ctrl_wdata        (ctrl_wdata),
        .ctrl_write_enable (ctrl_write_enable),
        .cms_en            (cms_en),
        .busy              (busy),
        .writes_done       (writes_done)
    );

    always #5 clk = ~clk;

    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    cms_ctrl_cmd_t exp_q[$];
    int unsigned   strobes_seen = 0;
    int unsigned   low_run = 0;
    int unsigned   first_low_run = 0;
    int unsigned   gap_run = 0;
    logic          seen_strobe = 1'b0;
    int unsigned   n_accepted = 0;
    int unsigned   first_block = 0;
    logic          block_armed = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        cms_ctrl_cmd_t e;
        if (ctrl_write_enable) begin
            strobes_seen++;
            if (strobes_seen == 1) first_low_run = low_run;
            check("strobe_cms_en_low", 32'(cms_en), 32'd0);
            if (seen_strobe) check("strobe_gap_ok", 32'(gap_run >= GAP_CYCLES + 1), 32'd1);
            seen_strobe = 1'b1;
            gap_run     = 0;
            if (exp_q.size() == 0) begin
                check("strobe_expected_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("strobe_addr", 32'(ctrl_addr), 32'(e.addr));
                check("strobe_wdata", ctrl_wdata, e.wdata);
            end
        end else begin
            gap_run++;
        end
        if (cms_en) low_run = 0;
        else        low_run++;
    end

    task automatic push(input ctrl_addr_t a, input logic [31:0] d, input logic l);
        int unsigned waited = 0;
        @(negedge clk);
        cmd_if.s_cmd_valid = 1'b1;
        cmd_if.s_cmd_addr  = a;
        cmd_if.s_cmd_wdata = d;
        cmd_if.s_cmd_last  = l;
        #1;
        while (!cmd_if.s_cmd_ready && waited < 200) begin
            if (block_armed) begin
                first_block = n_accepted;
                block_armed = 1'b0;
            end
            @(negedge clk);
            #1;
            waited++;
        end
        if (!cmd_if.s_cmd_ready) check("push_accept_timeout", 32'(cmd_if.s_cmd_ready), 32'd1);
        @(posedge clk);
        if (waited < 200) begin
            exp_q.push_back('{addr: a, wdata: d, last: l});
            n_accepted++;
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        cmd_if.s_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 500);
        if (busy) check(name, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_if.s_cmd_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_we"}, 32'(ctrl_write_enable), 32'd0);
        check({tag, "_cms_en"}, 32'(cms_en), 32'd0);
        check({tag, "_writes_done"}, 32'(writes_done), 32'd0);
        check({tag, "_ctrl_addr"}, 32'(ctrl_addr), 32'd0);
        check({tag, "_ctrl_wdata"}, ctrl_wdata, 32'd0);
    endtask

    initial begin
        int unsigned base;
        int unsigned n;
        cmd_if.s_cmd_valid = 1'b0;
        cmd_if.s_cmd_addr  = '0;
        cmd_if.s_cmd_wdata = '0;
        cmd_if.s_cmd_last  = 1'b0;
        sw_en = 1'b1;
        rst   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_cms_en_follows_sw_en", 32'(cms_en), 32'd1);
        check("idle_ready", 32'(cmd_if.s_cmd_ready), 32'd1);
        sw_en = 1'b0;
        @(negedge clk);
        check("idle_cms_en_sw_en_low", 32'(cms_en), 32'd0);
        sw_en = 1'b1;
        @(negedge clk);
        check("idle_cms_en_sw_en_high", 32'(cms_en), 32'd1);

        // Basic 3-command batch; cms_en low through PAUSE(2)+SETUP(1) before the first strobe.
        push(TRIGGER_TRACE_START_ADDRESS, 32'h8000_0100, 1'b0);
        push(TRIGGER_TRACE_START_ADDRESS_ENABLED, 32'h0000_0001, 1'b0);
        push(MONITORED_ADDRESS_RANGE_LOWER_BOUND, 32'h8000_0000, 1'b1);
        release_bus();
        wait_idle("t1_idle_timeout");
        check("t1_cms_en_after_resume", 32'(cms_en), 32'd1);
        check("t1_writes_done", 32'(writes_done), 32'd3);
        check("t1_low_before_first_strobe", first_low_run, 32'd3);
        check("t1_queue_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back stream: pops land on relative edges 5 and 8, so the FIFO reaches
        // 8 entries after the 10th accept and ready is first seen low then.
        base = n_accepted;
        block_armed = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push(ctrl_addr_t'(8'h40 + i), 32'hA000_0000 + 32'(i), i == 11);
        end
        release_bus();
        wait_idle("t2_idle_timeout");
        check("t2_accepted_before_full", first_block - base, 32'd10);
        check("t2_writes_done", 32'(writes_done), 32'd15);
        check("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // Batch without last parks in HOLD until the closing command arrives.
        push(8'h30, 32'h1111_0000, 1'b0);
        push(8'h31, 32'h2222_0000, 1'b0);
        release_bus();
        repeat (20) @(negedge clk);
        check("t3_state_hold", 32'(dut.state_q), 32'(HOLD));
        check("t3_cms_en_low", 32'(cms_en), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_writes_done", 32'(writes_done), 32'd17);
        push(8'h32, 32'h3333_0000, 1'b1);
        release_bus();
        wait_idle("t3_idle_timeout");
        check("t3_writes_done_final", 32'(writes_done), 32'd18);
        check("t3_cms_en_after_resume", 32'(cms_en), 32'd1);

        // Abort coincident with the 2nd strobe of a 4-command batch.
        for (int i = 0; i < 4; i++) begin
            push(ctrl_addr_t'(8'h60 + i), 32'hB000_0000 + 32'(i), i == 3);
        end
        release_bus();
        n = 0;
        while (!(ctrl_write_enable && writes_done == 16'd19) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n < 100) begin
            abort = 1'b1;
            #1;
            check("t4_ready_low_during_abort", 32'(cmd_if.s_cmd_ready), 32'd0);
            @(negedge clk);
            abort = 1'b0;
            check("t4_busy_after_abort", 32'(busy), 32'd0);
            check("t4_we_after_abort", 32'(ctrl_write_enable), 32'd0);
            check("t4_cms_en_after_abort", 32'(cms_en), 32'd1);
            check("t4_writes_done", 32'(writes_done), 32'd20);
            exp_q.delete();
            repeat (20) @(negedge clk);
            check("t4_stays_idle", 32'(busy), 32'd0);
            check("t4_writes_done_stable", 32'(writes_done), 32'd20);
        end else begin
            check("t4_second_strobe_timeout", n, 32'd0);
        end

        // Reset during HOLD of a 3-command batch.
        for (int i = 0; i < 3; i++) begin
            push(ctrl_addr_t'(8'h70 + i), 32'hC000_0000 + 32'(i), i == 2);
        end
        release_bus();
        n = 0;
        while (dut.state_q != HOLD && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("t5_hold_timeout", n, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("t5_no_activity_busy", 32'(busy), 32'd0);
        check("t5_no_activity_writes", 32'(writes_done), 32'd0);

        // Counter wrap: preset to 0xFFFE, then three strobes.
        @(negedge clk);
        force dut.writes_done_q = 16'hFFFE;
        #1;
        release dut.writes_done_q;
        @(negedge clk);
        check("t6_preset", 32'(writes_done), 32'h0000_FFFE);
        push(8'h01, 32'hD000_0001, 1'b0);
        push(8'h02, 32'hD000_0002, 1'b0);
        push(8'h03, 32'hD000_0003, 1'b1);
        release_bus();
        wait_idle("t6_idle_timeout");
        check("t6_wrapped", 32'(writes_done), 32'h0000_0001);
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
